axi4_cmd_master: RTL
====================

# axi4_cmd_master

Parametrised AXI4 master engine.
- Consumes 128-bit command words from the command FIFO over a valid/ready stream and issues AXI4 write and read bursts.
- Returns B and R channel results as 128-bit response words over a second valid/ready stream.
- Generalises the fixed 64/32-bit FIFO–decoder–master chain: data, address and ID widths are parameters.
- New behaviour: per-direction outstanding-burst limits and merged response arbitration.

## Interface
- DATA_W, 64, AXI data width; 32 or 64 only (data plus strobe must fit in 128 bits).
- ADDR_W, 32, AXI address width; 12..64.
- ID_W, 8, AXI ID width; 1..8.
- MAX_OUTST, 4, outstanding bursts allowed per direction; 1..15.
- ACLK  in  1  single clock; all logic on the rising edge.
- ARESETn  in  1  asynchronous, active-low reset.
- cmd_valid / cmd_ready  in / out  1  command stream handshake.
- cmd_data  in  128  header or write-data word.
- rsp_valid / rsp_ready  out / in  1  response stream handshake.
- rsp_data  out  128  response word.
- AWID / ARID  out  ID_W  burst ID.
- AWADDR / ARADDR  out  ADDR_W  start address.
- AWLEN / ARLEN, AWSIZE / ARSIZE, AWBURST / ARBURST  out  8, 3, 2  burst attributes.
- AWVALID / ARVALID  out  1  address valid.
- AWREADY / ARREADY  in  1  address ready.
- AWLOCK/ARLOCK, AWCACHE/ARCACHE, AWPROT/ARPROT  out  1, 4, 3  constants 0, 4'b0011, 3'b000.
- WDATA  out  DATA_W  write data; WSTRB  out  DATA_W/8  byte strobes.
- WLAST / WVALID  out  1; WREADY  in  1.
- BID / RID  in  ID_W; BRESP / RRESP  in  2; BVALID / RVALID  in  1.
- BREADY / RREADY  out  1.
- RDATA  in  DATA_W; RLAST  in  1.

## Operation
**Header word**
- [127:126] op: 01 write, 10 read, 00/11 illegal.
- [125:118] LEN; [117:110] ID (low ID_W bits used); [109:107] SIZE; [106:105] BURST; [ADDR_W-1:0] address.
- A write header is followed by exactly LEN+1 data words: data in [DATA_W-1:0], strobe in [DATA_W+DATA_W/8-1:DATA_W].

**FSM states: IDLE, AW, WD, AR.**
- IDLE: cmd_ready=1 except for a write header while wr_cnt==MAX_OUTST or a read header while rd_cnt==MAX_OUTST. A blocked header is held in place, not consumed.
- IDLE, on header accept: register the fields; write goes to AW, read goes to AR, illegal is consumed, dropped, and stays in IDLE.
- AW: AWVALID=1 until AWREADY, then WD.
- WD: zero-latency pass-through. WVALID=cmd_valid, cmd_ready=WREADY, WDATA/WSTRB taken from cmd_data.
- WD beat counter starts at 0. WLAST=1 when beat==LEN. After the WLAST handshake, go to IDLE.
- AR: ARVALID=1 until ARREADY, then IDLE.

**Outstanding counters (4 bits)**
- wr_cnt: +1 on AW handshake, −1 on B handshake.
- rd_cnt: +1 on AR handshake, −1 on an R handshake with RLAST.
- Increment and decrement in the same cycle leave the counter unchanged.

**Response slot (one register)**
- slot_avail = slot empty OR (rsp_valid AND rsp_ready).
- RREADY = slot_avail. BREADY = slot_avail AND NOT RVALID. R has fixed priority over B.
- Read word: [127:126]=10, [125]=RLAST, [124:123]=RRESP, [122:115]=RID zero-extended, [DATA_W-1:0]=RDATA, all other bits 0.
- Write word: [127:126]=01, [125]=0, [124:123]=BRESP, [122:115]=BID, all other bits 0.

## Timing
- Reset values: state IDLE, wr_cnt=rd_cnt=0, slot empty, rsp_valid=0, AWVALID=ARVALID=WVALID=0, all registered address/ID/LEN fields 0.
- Header accept to AWVALID/ARVALID: 1 cycle.
- AW handshake to first WVALID opportunity: next cycle.
- R/B handshake to rsp_valid: 1 cycle. Sustained throughput: 1 beat per cycle on W and on R.
- Once VALID is asserted it holds, with a stable payload, until READY.
- LEN=0 write: a single beat with WLAST=1.
- A new header is never accepted while in AW, WD or AR.
- Reset mid-burst: immediate return to reset values. No partial completion and no response is emitted.

## Structure
- Package axi4_cmd_pkg holds:
  - opcode constants;
  - header and response field bit positions;
  - LOCK/CACHE/PROT constants;
  - FSM state enum.
- Sub-module axi4_rsp_merge holds the R/B arbitration and the response slot. Its ports are the B and R channels plus the rsp stream.

## Test plan
- Write header op=01, LEN=3, ID=5, addr 0x1000, then 4 data words; AWREADY/WREADY held at 1 → AWADDR=0x1000, AWLEN=3, WLAST on beat 3 only; BRESP=0 → rsp_data[127:115]=01_0_00_00000101.
- Read LEN=1, ID=2; slave returns 2 beats 0xA, 0xB with RLAST on the 2nd → two response words, the second with [125]=1, RDATA=0xB, rd_cnt back to 0.
- MAX_OUTST=2 and BVALID held 0; issue 3 writes → third header held with cmd_ready=0; one B handshake → third AW issues on the following cycles.
- BVALID and RVALID asserted in the same cycle with rsp_ready=1 → R word emitted first, B word next cycle; rsp_ready=0 for 3 cycles → rsp_data stable, RREADY=BREADY=0.
- Illegal header op=11 → consumed in 1 cycle; no AWVALID, ARVALID or response.
- ARESETn pulsed low during WD beat 2 of LEN=7 → all VALIDs 0 asynchronously, counters 0; next write header is accepted normally.

Source files
------------

// File: rtl/axi4_cmd_pkg.sv
// Shared types and constants for the AXI4 command master.
// Command header / response word layouts, fixed AXI attributes, FSM states.
package axi4_cmd_pkg;

  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;

  localparam int HDR_OP_LO    = 126;
  localparam int HDR_LEN_LO   = 118;
  localparam int HDR_ID_LO    = 110;
  localparam int HDR_SIZE_LO  = 107;
  localparam int HDR_BURST_LO = 105;

  localparam int RSP_OP_LO   = 126;
  localparam int RSP_LAST    = 125;
  localparam int RSP_RESP_LO = 123;
  localparam int RSP_ID_LO   = 115;

  localparam logic       AXI_LOCK  = 1'b0;
  localparam logic [3:0] AXI_CACHE = 4'b0011;
  localparam logic [2:0] AXI_PROT  = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AW,
    ST_WD,
    ST_AR
  } state_t;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] len;
    logic [7:0] id;
    logic [2:0] size;
    logic [1:0] burst;
  } hdr_t;

  function automatic hdr_t hdr_decode(
    input logic [127:0] w
  );
    hdr_t h;
    h.op    = w[HDR_OP_LO +: 2];
    h.len   = w[HDR_LEN_LO +: 8];
    h.id    = w[HDR_ID_LO +: 8];
    h.size  = w[HDR_SIZE_LO +: 3];
    h.burst = w[HDR_BURST_LO +: 2];
    return h;
  endfunction

endpackage

// File: rtl/axi4_rsp_merge.sv
// Merges AXI R and B results into one registered response slot.
// R has fixed priority; B is only accepted when no R beat is offered.
module axi4_rsp_merge
  import axi4_cmd_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ID_W   = 8
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ID_W-1:0]   BID,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  input  logic [ID_W-1:0]   RID,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [127:0]      rsp_data
);

  logic         slot_avail;
  logic [127:0] r_word;
  logic [127:0] b_word;

  // Slot refills in the same cycle it drains, keeping 1 beat/cycle.
  assign slot_avail = ~rsp_valid | rsp_ready;
  assign RREADY     = slot_avail;
  assign BREADY     = slot_avail & ~RVALID;

  always_comb begin
    r_word = '0;
    r_word[RSP_OP_LO +: 2]   = OP_RD;
    r_word[RSP_LAST]         = RLAST;
    r_word[RSP_RESP_LO +: 2] = RRESP;
    r_word[RSP_ID_LO +: ID_W] = RID;
    r_word[DATA_W-1:0]       = RDATA;
  end

  always_comb begin
    b_word = '0;
    b_word[RSP_OP_LO +: 2]   = OP_WR;
    b_word[RSP_RESP_LO +: 2] = BRESP;
    b_word[RSP_ID_LO +: ID_W] = BID;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else if (slot_avail) begin
      rsp_valid <= RVALID | BVALID;
      if (RVALID) begin
        rsp_data <= r_word;
      end else if (BVALID) begin
        rsp_data <= b_word;
      end
    end
  end

endmodule

// File: rtl/axi4_cmd_master.sv
// AXI4 master driven by 128-bit command words; returns B/R results as
// 128-bit response words. Write data streams straight through from cmd.
module axi4_cmd_master
  import axi4_cmd_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 32,
  parameter int ID_W      = 8,
  parameter int MAX_OUTST = 4
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [127:0]        cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [127:0]        rsp_data,
  output logic [ID_W-1:0]     AWID,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [7:0]          AWLEN,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic                AWLOCK,
  output logic [3:0]          AWCACHE,
  output logic [2:0]          AWPROT,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [ID_W-1:0]     BID,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY,
  output logic [ID_W-1:0]     ARID,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic [7:0]          ARLEN,
  output logic [2:0]          ARSIZE,
  output logic [1:0]          ARBURST,
  output logic                ARLOCK,
  output logic [3:0]          ARCACHE,
  output logic [2:0]          ARPROT,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [ID_W-1:0]     RID,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RLAST,
  input  logic                RVALID,
  output logic                RREADY
);

  localparam logic [3:0] OUTST_MAX = 4'(MAX_OUTST);

  state_t              state;
  hdr_t                hdr;
  logic                hdr_wr;
  logic                hdr_rd;
  logic                hdr_block;
  logic [ADDR_W-1:0]   addr_q;
  logic [ID_W-1:0]     id_q;
  logic [7:0]          len_q;
  logic [2:0]          size_q;
  logic [1:0]          burst_q;
  logic [7:0]          beat_q;
  logic                aw_valid_q;
  logic                ar_valid_q;
  logic [3:0]          wr_cnt;
  logic [3:0]          rd_cnt;
  logic                aw_hs;
  logic                ar_hs;
  logic                b_hs;
  logic                r_done;
  logic                in_wd;
  logic                unused_bits;

  assign hdr = hdr_decode(cmd_data);
  assign unused_bits = ^{cmd_data, hdr};

  always_comb begin
    hdr_wr = 1'b0;
    hdr_rd = 1'b0;
    unique case (1'b1)
      hdr.op == OP_WR: hdr_wr = 1'b1;
      hdr.op == OP_RD: hdr_rd = 1'b1;
      default: ;
    endcase
  end

  // A header that would exceed its direction's limit waits on the stream.
  assign hdr_block = (hdr_wr && wr_cnt == OUTST_MAX)
                   | (hdr_rd && rd_cnt == OUTST_MAX);

  always_comb begin
    cmd_ready = 1'b0;
    unique case (state)
      ST_IDLE: cmd_ready = ~hdr_block;
      ST_WD:   cmd_ready = WREADY;
      default: cmd_ready = 1'b0;
    endcase
  end

  assign in_wd  = (state == ST_WD);
  assign WVALID = in_wd & cmd_valid;
  assign WLAST  = in_wd & (beat_q == len_q);
  assign WDATA  = cmd_data[DATA_W-1:0];
  assign WSTRB  = cmd_data[DATA_W +: DATA_W/8];

  assign AWVALID = aw_valid_q;
  assign AWID    = id_q;
  assign AWADDR  = addr_q;
  assign AWLEN   = len_q;
  assign AWSIZE  = size_q;
  assign AWBURST = burst_q;
  assign AWLOCK  = AXI_LOCK;
  assign AWCACHE = AXI_CACHE;
  assign AWPROT  = AXI_PROT;

  assign ARVALID = ar_valid_q;
  assign ARID    = id_q;
  assign ARADDR  = addr_q;
  assign ARLEN   = len_q;
  assign ARSIZE  = size_q;
  assign ARBURST = burst_q;
  assign ARLOCK  = AXI_LOCK;
  assign ARCACHE = AXI_CACHE;
  assign ARPROT  = AXI_PROT;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= ST_IDLE;
      aw_valid_q <= 1'b0;
      ar_valid_q <= 1'b0;
      addr_q     <= '0;
      id_q       <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      beat_q     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready && (hdr_wr || hdr_rd)) begin
            addr_q  <= cmd_data[ADDR_W-1:0];
            id_q    <= hdr.id[ID_W-1:0];
            len_q   <= hdr.len;
            size_q  <= hdr.size;
            burst_q <= hdr.burst;
            beat_q  <= '0;
            if (hdr_wr) begin
              state      <= ST_AW;
              aw_valid_q <= 1'b1;
            end else begin
              state      <= ST_AR;
              ar_valid_q <= 1'b1;
            end
          end
        end
        ST_AW: begin
          if (AWREADY) begin
            aw_valid_q <= 1'b0;
            state      <= ST_WD;
          end
        end
        ST_WD: begin
          if (cmd_valid && WREADY) begin
            if (WLAST) begin
              state <= ST_IDLE;
            end else begin
              beat_q <= beat_q + 8'd1;
            end
          end
        end
        ST_AR: begin
          if (ARREADY) begin
            ar_valid_q <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign aw_hs  = aw_valid_q & AWREADY;
  assign ar_hs  = ar_valid_q & ARREADY;
  assign b_hs   = BVALID & BREADY;
  assign r_done = RVALID & RREADY & RLAST;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      case ({aw_hs, b_hs})
        2'b10:   wr_cnt <= wr_cnt + 4'd1;
        2'b01:   wr_cnt <= wr_cnt - 4'd1;
        default: wr_cnt <= wr_cnt;
      endcase
      case ({ar_hs, r_done})
        2'b10:   rd_cnt <= rd_cnt + 4'd1;
        2'b01:   rd_cnt <= rd_cnt - 4'd1;
        default: rd_cnt <= rd_cnt;
      endcase
    end
  end

  axi4_rsp_merge #(
    .DATA_W (DATA_W),
    .ID_W   (ID_W)
  ) u_rsp_merge (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .BID       (BID),
    .BRESP     (BRESP),
    .BVALID    (BVALID),
    .BREADY    (BREADY),
    .RID       (RID),
    .RDATA     (RDATA),
    .RRESP     (RRESP),
    .RLAST     (RLAST),
    .RVALID    (RVALID),
    .RREADY    (RREADY),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data)
  );

endmodule
